// File: rtl/demux_rr_arbiter_if.sv
// Handshake and demux-side bundle shared by the serial source, the arbiter and the sinks.
// The slave modport is the arbiter's view; master is the source/sink environment.
interface demux_rr_arbiter_if;
    logic [3:0] req;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic [1:0] sel;
    logic       d_out;
    logic [3:0] grant;
    logic       burst_done;

    modport master (
        output req,
        output in_valid,
        output in_data,
        input  in_ready,
        input  sel,
        input  d_out,
        input  grant,
        input  burst_done
    );

    modport slave (
        input  req,
        input  in_valid,
        input  in_data,
        output in_ready,
        output sel,
        output d_out,
        output grant,
        output burst_done
    );
endinterface

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter that lends one serial bit source to four demux sinks,
// one fixed-length burst per grant, with early release when the owner drops its request.
module demux_rr_arbiter #(
    parameter int BURST = 4,
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    demux_rr_arbiter_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_next;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_next;
    logic             r_burst_done;
    logic             w_burst_done_next;

    logic [1:0]       w_cand [4];
    logic [3:0]       w_hit;
    logic [1:0]       w_pick;
    logic             w_any_req;
    logic             w_owner_req;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_d_out;

    // Candidate k is ptr+1+k, so the last candidate is the previous owner itself.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand[gi] = r_ptr + 2'(gi + 1);
            assign w_hit[gi]  = bus.req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_pick = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_pick = w_cand[k];
            end
        end
    end

    assign w_any_req   = |bus.req;
    assign w_owner_req = |(bus.req & r_grant);
    assign w_xfer      = bus.in_valid & w_in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= 2'd3;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_grant      <= 4'b0000;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_cnt        <= w_cnt_next;
            r_sel        <= w_sel_next;
            r_grant      <= w_grant_next;
            r_burst_done <= w_burst_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_cnt_next        = r_cnt;
        w_sel_next        = r_sel;
        w_grant_next      = r_grant;
        w_burst_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_BUSY;
                    w_ptr_next   = w_pick;
                    w_sel_next   = w_pick;
                    w_grant_next = 4'b0001 << w_pick;
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                if (w_xfer) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                // A final bit completes the burst even if the owner releases in the same cycle.
                if (w_xfer && (r_cnt == LAST_CNT)) begin
                    w_state_next      = S_IDLE;
                    w_grant_next      = 4'b0000;
                    w_burst_done_next = 1'b1;
                end else if (!w_owner_req) begin
                    w_state_next = S_IDLE;
                    w_grant_next = 4'b0000;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = 4'b0000;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready = (r_state == S_BUSY);
        w_d_out    = bus.in_data & bus.in_valid & (r_state == S_BUSY);
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.d_out      = w_d_out;
    assign bus.sel        = r_sel;
    assign bus.grant      = r_grant;
    assign bus.burst_done = r_burst_done;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Directed and randomized bench for demux_rr_arbiter, checked against a per-cycle
// behavioural model of the round-robin burst rules.
module tb_demux_rr_arbiter;

    localparam int BURST = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;

    demux_rr_arbiter_if bus ();

    demux_rr_arbiter #(
        .BURST (BURST),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the source, how many bits it has had, who was served last.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_bits;
    bit m_done;

    logic [3:0] obs_grant;
    logic [1:0] obs_sel;
    logic       obs_dout;
    logic       obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = 3;
        m_bits  = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_check(input logic v, input logic d);
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("sel", 32'(bus.sel), 32'(m_owner));
        chk("in_ready", 32'(bus.in_ready), 32'(m_busy));
        chk("d_out", 32'(bus.d_out), 32'(m_busy & v & d));
        chk("burst_done", 32'(bus.burst_done), 32'(m_done));
    endtask

    task automatic model_advance(input logic [3:0] r, input logic v);
        m_done = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                if (!m_busy && r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_last  = m_owner;
                    m_busy  = 1'b1;
                    m_bits  = 0;
                end
            end
        end else begin
            if (v) begin
                m_bits++;
                if (m_bits == BURST) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (m_busy && !r[m_owner]) m_busy = 1'b0;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic v, input logic d);
        @(negedge clk);
        bus.req      = r;
        bus.in_valid = v;
        bus.in_data  = d;
        #1;
        obs_grant = bus.grant;
        obs_sel   = bus.sel;
        obs_dout  = bus.d_out;
        obs_done  = bus.burst_done;
        model_check(v, d);
        @(posedge clk);
        model_advance(r, v);
    endtask

    // Reset asserted between clock edges with a valid '1' bit on the source.
    task automatic reset_mid();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        #2;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #1;
        model_reset();
        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_sel", 32'(bus.sel), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_d_out", 32'(bus.d_out), 32'(0));
        chk("rst_burst_done", 32'(bus.burst_done), 32'(0));
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sr_bits [4];
        int         exp_g [5];
        int         exp_s [5];
        int         got_g [$];
        int         got_s [$];
        int         n_done;
        logic [3:0] prev_g;
        logic [3:0] rr;
        logic       rv;
        logic       rd;

        sr_bits = '{1, 0, 1, 1};
        exp_g   = '{1, 2, 4, 8, 1};
        exp_s   = '{0, 1, 2, 3, 0};

        rst_n        = 1'b0;
        bus.req      = 4'b0000;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        model_reset();
        #12;
        reset_mid();

        // Single requester, 1,0,1,1
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 1'b1, sr_bits[i][0]);
            chk("sr_grant", 32'(obs_grant), 32'(1));
            chk("sr_dout", 32'(obs_dout), 32'(sr_bits[i]));
        end
        step(4'b0001, 1'b1, 1'b0);
        chk("sr_done", 32'(obs_done), 32'(1));
        chk("sr_idle_grant", 32'(obs_grant), 32'(0));
        step(4'b0001, 1'b1, 1'b1);
        chk("sr_regrant", 32'(obs_grant), 32'(1));

        // Async reset mid-burst, then all four requesting
        reset_mid();
        prev_g = 4'b0000;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            step(4'b1111, 1'b1, 1'($urandom_range(0, 1)));
            if (obs_grant != 4'b0000 && prev_g == 4'b0000) begin
                got_g.push_back(int'(obs_grant));
                got_s.push_back(int'(obs_sel));
            end
            if (obs_done) n_done++;
            prev_g = obs_grant;
        end
        chk("all_nbursts", 32'(got_g.size()), 32'(5));
        for (int i = 0; i < 5 && i < got_g.size(); i++) begin
            chk("all_grant_seq", 32'(got_g[i]), 32'(exp_g[i]));
            chk("all_sel_seq", 32'(got_s[i]), 32'(exp_s[i]));
        end
        chk("all_ndone", 32'(n_done), 32'(4));

        // Stall for 3 cycles after 2 transfers
        reset_mid();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 1'b0, 1'b1);
            chk("stall_grant", 32'(obs_grant), 32'(1));
            chk("stall_dout", 32'(obs_dout), 32'(0));
        end
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        chk("stall_last_grant", 32'(obs_grant), 32'(1));
        step(4'b0000, 1'b0, 1'b0);
        chk("stall_done", 32'(obs_done), 32'(1));
        step(4'b0000, 1'b0, 1'b0);
        chk("stall_done_once", 32'(obs_done), 32'(0));

        // Early release of sink 2 while sink 3 waits
        reset_mid();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b1100, 1'b1, 1'b1);
        chk("er_grant", 32'(obs_grant), 32'(4));
        step(4'b1100, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        chk("er_idle_grant", 32'(obs_grant), 32'(0));
        chk("er_no_done", 32'(obs_done), 32'(0));
        step(4'b1000, 1'b0, 1'b0);
        chk("er_next_grant", 32'(obs_grant), 32'(8));

        // Round-robin skip from ptr=1
        reset_mid();
        step(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, 1'b1);
        step(4'b1001, 1'b0, 1'b0);
        chk("rr_done", 32'(obs_done), 32'(1));
        step(4'b1001, 1'b0, 1'b0);
        chk("rr_grant", 32'(obs_grant), 32'(8));

        // Randomized traffic, occasionally reset mid-cycle
        rr = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_mid();
            end else begin
                if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
                rv = ($urandom_range(0, 3) != 0);
                rd = 1'($urandom_range(0, 1));
                step(rr, rv, rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
